// File: rtl/pe_weight_loader_pkg.sv
// Shared definitions for the PE weight loader: weight/slot widths and FSM state encoding.
// Imported by pe_weight_loader and pe_wload_cnt.
package pe_weight_loader_pkg;

    localparam int WEIGHT_W    = 8;
    localparam int NUM_WSLOT   = 4;
    localparam int WSLOT_SEL_W = 2;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/pe_wload_cnt.sv
// Nested PE/slot counter for the weight loader, slot-major order, with last-beat flag.
// In broadcast mode the PE index stays at 0 and every beat advances the slot.
module pe_wload_cnt
    import pe_weight_loader_pkg::*;
#(
    parameter int  NUM_PE   = 16,
    localparam int PE_IDX_W = $clog2(NUM_PE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   advance_i,
    input  logic                   bcast_i,
    input  logic [WSLOT_SEL_W-1:0] last_slot_i,
    output logic [PE_IDX_W-1:0]    pe_cnt_o,
    output logic [WSLOT_SEL_W-1:0] slot_cnt_o,
    output logic                   last_o
);

    logic [PE_IDX_W-1:0]    pe_cnt_q, pe_cnt_d;
    logic [WSLOT_SEL_W-1:0] slot_cnt_q, slot_cnt_d;
    logic                   pe_wrap;

    assign pe_wrap = (pe_cnt_q == PE_IDX_W'(NUM_PE - 1));

    always_comb begin
        // NOTE: default every combinational output first so no path can infer a latch.
        pe_cnt_d   = pe_cnt_q;
        slot_cnt_d = slot_cnt_q;
        if (clear_i) begin
            pe_cnt_d   = '0;
            slot_cnt_d = '0;
        end else if (advance_i) begin
            if (bcast_i) begin
                pe_cnt_d   = '0;
                slot_cnt_d = slot_cnt_q + WSLOT_SEL_W'(1);
            end else if (pe_wrap) begin
                pe_cnt_d   = '0;
                slot_cnt_d = slot_cnt_q + WSLOT_SEL_W'(1);
            end else begin
                pe_cnt_d = pe_cnt_q + PE_IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_cnt_q   <= '0;
            slot_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            pe_cnt_q   <= pe_cnt_d;
            slot_cnt_q <= slot_cnt_d;
        end
    end

    assign pe_cnt_o   = pe_cnt_q;
    assign slot_cnt_o = slot_cnt_q;
    assign last_o     = (bcast_i || pe_wrap) && (slot_cnt_q == last_slot_i);

endmodule

// File: rtl/pe_weight_loader.sv
// Weight loader: streams signed weights into the per-PE weight slots, slot-major, then pulses done.
// Optional broadcast mode (one beat written to every PE) is enabled with macro WLOAD_BCAST_EN.
module pe_weight_loader
    import pe_weight_loader_pkg::*;
#(
    parameter int  NUM_PE   = 16,
    localparam int PE_IDX_W = $clog2(NUM_PE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WSLOT_SEL_W-1:0]     num_slots,
    input  logic                       bcast,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WEIGHT_W-1:0] in_data,
    output logic signed [WEIGHT_W-1:0] weight_load,
    output logic [NUM_PE-1:0]          weight_load_en,
    output logic [WSLOT_SEL_W-1:0]     weight_load_sel,
    output logic                       busy,
    output logic                       done
);

    state_t                     state_q, state_d;
    logic [WSLOT_SEL_W-1:0]     num_slots_q, num_slots_d;
    logic signed [WEIGHT_W-1:0] wl_q, wl_d;
    logic [WSLOT_SEL_W-1:0]     sel_q, sel_d;
    logic [NUM_PE-1:0]          en_q, en_d;

    logic                   beat_acc;
    logic                   cnt_clear;
    logic                   cnt_last;
    logic                   bcast_mode;
    logic [PE_IDX_W-1:0]    pe_cnt;
    logic [WSLOT_SEL_W-1:0] slot_cnt;

    assign in_ready = (state_q == ST_LOAD);
    assign beat_acc = in_valid && in_ready;

`ifdef WLOAD_BCAST_EN
    logic bcast_q, bcast_d;

    assign bcast_d    = (state_q == ST_IDLE && start) ? bcast : bcast_q;
    assign bcast_mode = bcast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcast_q <= 1'b0;
        else        bcast_q <= bcast_d;
    end
`else
    logic unused_bcast;

    assign unused_bcast = bcast;
    assign bcast_mode   = 1'b0;
`endif

    pe_wload_cnt #(.NUM_PE(NUM_PE)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (cnt_clear),
        .advance_i  (beat_acc),
        .bcast_i    (bcast_mode),
        .last_slot_i(num_slots_q),
        .pe_cnt_o   (pe_cnt),
        .slot_cnt_o (slot_cnt),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d     = state_q;
        num_slots_d = num_slots_q;
        cnt_clear   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // start outranks abort here; abort has nothing to cancel yet
                if (start) begin
                    state_d     = ST_LOAD;
                    num_slots_d = num_slots;
                    cnt_clear   = 1'b1;
                end
            end
            ST_LOAD: begin
                if (abort)                     state_d = ST_IDLE;
                else if (beat_acc && cnt_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // A beat accepted alongside abort is still written out; only later beats are refused.
    always_comb begin
        wl_d  = wl_q;
        sel_d = sel_q;
        en_d  = '0;
        if (beat_acc) begin
            wl_d  = in_data;
            sel_d = slot_cnt;
            en_d  = bcast_mode ? {NUM_PE{1'b1}} : (NUM_PE'(1) << pe_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            num_slots_q <= '0;
            wl_q        <= '0;
            sel_q       <= '0;
            en_q        <= '0;
        end else begin
            state_q     <= state_d;
            num_slots_q <= num_slots_d;
            wl_q        <= wl_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
        end
    end

    assign weight_load     = wl_q;
    assign weight_load_sel = sel_q;
    assign weight_load_en  = en_q;
    assign busy            = (state_q != ST_IDLE);
    assign done            = (state_q == ST_DONE);

endmodule
